// File: rtl/fl_ticket_scheduler_if.sv
// fl_ticket_scheduler_if: ticket issue and ticket reclaim handshakes between the
// scheduler (master) and the FL ticket splitter (slave).
interface fl_ticket_scheduler_if #(
    parameter int OUTPUT_COUNT = 2,
    parameter int TICKET_WIDTH = 4
);
    logic [TICKET_WIDTH-1:0]              ticket;
    logic                                 ticket_vld;
    logic                                 ticket_rq;
    logic [OUTPUT_COUNT*TICKET_WIDTH-1:0] ret_data;
    logic [OUTPUT_COUNT-1:0]              ret_vld;
    logic [OUTPUT_COUNT-1:0]              ret_rq;
    modport master (output ticket, ticket_vld, ret_rq, input ticket_rq, ret_data, ret_vld);
    modport slave  (input ticket, ticket_vld, ret_rq, output ticket_rq, ret_data, ret_vld);
endinterface

// File: rtl/fl_ticket_scheduler.sv
// fl_ticket_scheduler: owns the splitter's ticket pool, issuing free IDs in FIFO order
// and reclaiming returned IDs from the output ports with round-robin arbitration.
module fl_ticket_scheduler #(
    parameter int OUTPUT_COUNT = 2,
    parameter int TICKET_WIDTH = 4,
    parameter int TICKET_COUNT = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    fl_ticket_scheduler_if.master   bus,
    output logic [TICKET_WIDTH:0]   in_flight_o,
    output logic                    err_o
);
    localparam int OC = OUTPUT_COUNT;
    localparam int TW = TICKET_WIDTH;
    localparam int PW = OC > 1 ? $clog2(OC) : 1;
    localparam logic [TW:0] TC = (TW+1)'(TICKET_COUNT);

    typedef enum logic {INIT, RUN} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   pool_q [2**TW];
    logic [TW-1:0]   head_q, head_d, tail_q, tail_d, wdata;
    logic [TW:0]     count_q, count_d, in_flight_q, in_flight_d;
    logic [PW-1:0]   gptr_q, gptr_d, grant;
    logic            err_q, err_d, run, full, has_grant, issue, reclaim, we;

    // Descending scan so the first valid port at or after the grant pointer wins
    always_comb begin
        has_grant = 1'b0;
        grant = gptr_q;
        for (int j = OC - 1; j >= 0; j--) begin
            if (bus.ret_vld[(int'(gptr_q) + j) % OC]) begin
                has_grant = 1'b1;
                grant = PW'((int'(gptr_q) + j) % OC);
            end
        end
    end

    always_comb begin
        run = state_q == RUN;
        full = count_q == TC;
        bus.ticket_vld = run && en_i && count_q != '0;
        bus.ticket = bus.ticket_vld ? pool_q[head_q] : '0;
        bus.ret_rq = (run && !full && has_grant) ? OC'(1) << grant : '0;
        issue = bus.ticket_vld && bus.ticket_rq;
        reclaim = |bus.ret_rq;
        // INIT fills slot k with ID k through the same tail write port used for reclaim
        we = !run || reclaim;
        wdata = run ? bus.ret_data[grant*TW +: TW] : tail_q;
        head_d = head_q + TW'(issue);
        tail_d = tail_q + TW'(we);
        count_d = count_q + (TW+1)'(we) - (TW+1)'(issue);
        in_flight_d = in_flight_q + (TW+1)'(issue) - (TW+1)'(reclaim);
        gptr_d = reclaim ? (grant == PW'(OC - 1) ? '0 : grant + PW'(1)) : gptr_q;
        err_d = err_q || (run && full && |bus.ret_vld);
        state_d = (!run && tail_q == TW'(TICKET_COUNT - 1)) ? RUN : state_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            in_flight_q <= '0;
            gptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            in_flight_q <= in_flight_d;
            gptr_q <= gptr_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) pool_q[tail_q] <= wdata;
    end

    assign in_flight_o = in_flight_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_fl_ticket_scheduler.sv
// tb_fl_ticket_scheduler: randomized scoreboard bench; the reference keeps the pool as a
// queue of IDs and the splitter side as per-port return slots.
module tb_fl_ticket_scheduler;
    localparam int OC = 2, TW = 4, TC = 16;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [TW:0] in_flight;
    logic err;
    int tests = 0, fails = 0;
    int pool[$], outst[$], exp_q[$];
    int cyc, m_inflight, gp, p_grant, e_tk;
    bit m_err, e_vld, p_issue, p_err, m_en, m_rq;
    int slot_v[OC], slot_d[OC];
    logic [OC-1:0] e_rq;

    fl_ticket_scheduler_if #(.OUTPUT_COUNT(OC), .TICKET_WIDTH(TW)) bus();
    fl_ticket_scheduler #(.OUTPUT_COUNT(OC), .TICKET_WIDTH(TW), .TICKET_COUNT(TC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .bus(bus),
        .in_flight_o(in_flight), .err_o(err));

    always #5 clk = ~clk;

    task automatic fail_now(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        fails++;
        $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) fail_now(nm, act, exp);
        else tests++;
    endtask

    task automatic model_reset();
        pool.delete(); outst.delete(); exp_q.delete();
        cyc = 0; m_inflight = 0; m_err = 0; gp = 0;
        p_issue = 0; p_grant = -1; p_err = 0; e_vld = 0; e_rq = '0; e_tk = 0;
        for (int i = 0; i < OC; i++) begin slot_v[i] = 0; slot_d[i] = 0; end
    endtask

    task automatic predict();
        bit run, full, any;
        int g = -1;
        run = cyc >= TC;
        full = pool.size() == TC;
        e_vld = run && m_en && pool.size() > 0;
        e_tk = e_vld ? pool[0] : 0;
        p_issue = e_vld && m_rq;
        any = 0;
        for (int k = 0; k < OC; k++) begin
            int i;
            i = (gp + k) % OC;
            if (slot_v[i] != 0) any = 1;
            if (run && !full && slot_v[i] != 0 && g < 0) g = i;
        end
        p_grant = g;
        e_rq = (g >= 0) ? OC'(1) << g : '0;
        p_err = run && full && any;
        if (p_issue) exp_q.push_back(pool[0]);
        en = m_en;
        bus.ticket_rq = m_rq;
        for (int i = 0; i < OC; i++) begin
            bus.ret_vld[i] = slot_v[i] != 0;
            bus.ret_data[i*TW +: TW] = TW'(slot_d[i]);
        end
    endtask

    task automatic model_edge();
        if (cyc < TC) pool.push_back(cyc);
        if (p_issue) begin outst.push_back(pool.pop_front()); m_inflight++; end
        if (p_grant >= 0) begin
            pool.push_back(slot_d[p_grant]);
            slot_v[p_grant] = 0;
            m_inflight--;
            gp = (p_grant + 1) % OC;
        end
        if (p_err) m_err = 1;
        cyc++;
    endtask

    task automatic rand_inputs();
        m_en = $urandom_range(0, 3) != 0;
        m_rq = $urandom_range(0, 2) != 0;
        for (int i = 0; i < OC; i++) begin
            if (slot_v[i] == 0 && outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                int idx;
                idx = $urandom_range(0, outst.size() - 1);
                slot_d[i] = outst[idx];
                outst.delete(idx);
                slot_v[i] = 1;
            end
        end
    endtask

    task automatic cycle(input bit rnd);
        @(posedge clk);
        model_edge();
        #1;
        if (rnd) rand_inputs();
        predict();
    endtask

    task automatic pulse_reset(string nm);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check({nm, "_vld"}, bus.ticket_vld, 0);
        check({nm, "_ret_rq"}, bus.ret_rq, 0);
        check({nm, "_in_flight"}, in_flight, 0);
        check({nm, "_err"}, err, 0);
        check({nm, "_ticket"}, bus.ticket, 0);
        repeat (2) @(posedge clk);
        model_reset();
        #3 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("ticket_vld", bus.ticket_vld, e_vld);
            check("ret_rq", bus.ret_rq, e_rq);
            check("in_flight", in_flight, m_inflight);
            check("err", err, m_err);
            if (bus.ticket_vld && bus.ticket_rq) begin
                if (exp_q.size() == 0) fail_now("unexpected_issue", bus.ticket, 0);
                else check("ticket", bus.ticket, exp_q.pop_front());
            end else if (exp_q.size() > 0) begin
                fail_now("missed_issue", 0, exp_q.pop_front());
            end
        end
    end

    initial begin
        int q0[$], q1[$];
        int ord[4];
        logic [OC-1:0] rq_exp[4];
        model_reset();
        m_en = 0; m_rq = 0;
        bus.ticket_rq = 1'b0; bus.ret_vld = '0; bus.ret_data = '0;
        #2;
        check("rst_vld", bus.ticket_vld, 0);
        check("rst_ret_rq", bus.ret_rq, 0);
        check("rst_in_flight", in_flight, 0);
        check("rst_err", err, 0);
        check("rst_ticket", bus.ticket, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        // Init, then drain all tickets in order
        m_en = 1; m_rq = 1;
        repeat (TC) cycle(0);
        @(negedge clk);
        check("t1_first_ticket", bus.ticket, 0);
        repeat (TC + 3) cycle(0);
        @(negedge clk);
        check("t1_in_flight", in_flight, TC);
        check("t1_vld_empty", bus.ticket_vld, 0);
        // Round-robin reclaim with both ports valid
        m_en = 0; m_rq = 0;
        q0 = '{3, 5}; q1 = '{7, 9};
        foreach (q0[i]) outst.delete(outst.find_first_index(x) with (x == q0[i])[0]);
        foreach (q1[i]) outst.delete(outst.find_first_index(x) with (x == q1[i])[0]);
        rq_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            model_edge();
            #1;
            if (slot_v[0] == 0 && q0.size() > 0) begin slot_d[0] = q0.pop_front(); slot_v[0] = 1; end
            if (slot_v[1] == 0 && q1.size() > 0) begin slot_d[1] = q1.pop_front(); slot_v[1] = 1; end
            predict();
            @(negedge clk);
            check("t2_ret_rq", bus.ret_rq, rq_exp[n]);
        end
        m_en = 1; m_rq = 1;
        ord = '{3, 7, 5, 9};
        for (int n = 0; n < 4; n++) begin
            cycle(0);
            @(negedge clk);
            check("t2_order", bus.ticket, ord[n]);
        end
        repeat (600) cycle(1);
        // Mid-operation reset, init reruns and issue restarts at 0
        pulse_reset("t6");
        m_en = 1; m_rq = 1;
        repeat (TC) cycle(0);
        @(negedge clk);
        check("t6_restart_vld", bus.ticket_vld, 1);
        check("t6_restart_ticket", bus.ticket, 0);
        repeat (6) cycle(0);
        @(negedge clk);
        check("t6_in_flight", in_flight, 6);
        // Return attempted into a full pool
        pulse_reset("t5");
        m_en = 0; m_rq = 0;
        repeat (TC) cycle(0);
        slot_d[0] = 0; slot_v[0] = 1;
        cycle(0);
        @(negedge clk);
        check("t5_ret_rq_full", bus.ret_rq, 0);
        check("t5_err_pre", err, 0);
        cycle(0);
        @(negedge clk);
        check("t5_err_set", err, 1);
        slot_v[0] = 0;
        repeat (3) cycle(0);
        @(negedge clk);
        check("t5_err_sticky", err, 1);
        // EN gating keeps the head ticket
        m_en = 1; m_rq = 0;
        cycle(0);
        @(negedge clk);
        check("t4_vld_on", bus.ticket_vld, 1);
        check("t4_ticket", bus.ticket, 0);
        m_en = 0; m_rq = 1;
        for (int n = 0; n < 3; n++) begin
            cycle(0);
            @(negedge clk);
            check("t4_vld_off", bus.ticket_vld, 0);
        end
        m_en = 1;
        cycle(0);
        @(negedge clk);
        check("t4_resume_ticket", bus.ticket, 0);
        cycle(0);
        @(negedge clk);
        check("t4_next_ticket", bus.ticket, 1);
        repeat (300) cycle(1);
        @(negedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        check("final_err_sticky", err, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
